// File: rtl/outer_loop_ctrl.sv
// outer_loop_ctrl
//   Outer-loop sequencer for the radix-78 inner-loop multiplier. It walks the
//   B operand one digit per iteration: it reads the digit from the B RAM,
//   registers it onto il_bi, fires il_en, waits for the inner loop's
//   completion level, then pulses the accumulator with the digit index.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, abort        operation control from the modexp/montgomery controller
//   busy                high in every state except IDLE
//   done/aborted/err    mutually exclusive one-cycle completion pulses
//   b_rd, b_addr        B RAM read strobe / address (digit index)
//   b_rdata             B RAM data, valid the cycle after b_rd
//   il_en, il_bi        inner-loop start pulse / registered digit
//   il_en_out           inner-loop completion level
//   acc_valid, acc_idx, acc_last   accumulator strobe, digit index, last flag
module outer_loop_ctrl #(
  parameter int radix   = 78,
  parameter int digits  = 40,
  parameter int addr_w  = 6,
  parameter int timeout = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic              b_rd,
  output logic [addr_w-1:0] b_addr,
  input  logic [radix-1:0]  b_rdata,
  output logic              il_en,
  output logic [radix-1:0]  il_bi,
  input  logic              il_en_out,
  output logic              acc_valid,
  output logic [addr_w-1:0] acc_idx,
  output logic              acc_last
);

  localparam int WC_W = $clog2(timeout + 1);
  localparam logic [addr_w-1:0] LAST_IDX = addr_w'(digits - 1);
  localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(timeout - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_SKIP, S_WAIT, S_ACC, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [addr_w-1:0] idx, idx_n;
  logic [WC_W-1:0]   wcnt, wcnt_n;
  logic              abort_flag, abort_flag_n;
  logic              aborted_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      wcnt       <= '0;
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
      err        <= 1'b0;
      il_bi      <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wcnt       <= wcnt_n;
      abort_flag <= abort_flag_n;
      aborted    <= aborted_n;
      err        <= err_n;
      // Digit only moves at LOAD->ISSUE; the multipliers need it held to WAIT exit.
      if (state == S_LOAD) il_bi <= b_rdata;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    wcnt_n       = wcnt;
    abort_flag_n = abort_flag;
    aborted_n    = 1'b0;
    err_n        = 1'b0;
    unique case (state)
      S_IDLE: begin
        // abort wins over a simultaneous start; nothing is pulsed
        if (start && !abort) begin
          state_n = S_FETCH;
          idx_n   = '0;
        end
      end
      S_FETCH, S_LOAD: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else begin
          state_n = (state == S_FETCH) ? S_LOAD : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) abort_flag_n = 1'b1;
        state_n = S_SKIP;
      end
      S_SKIP: begin
        // il_en_out here is still the previous digit's level; never sample it
        if (abort) abort_flag_n = 1'b1;
        wcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        wcnt_n = wcnt + WC_W'(1);
        if (abort) abort_flag_n = 1'b1;
        if (il_en_out) begin
          if (abort_flag || abort) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
          end else begin
            state_n = S_ACC;
          end
        end else if (wcnt == WC_LAST) begin
          // timeout takes precedence over a pending abort
          state_n = S_IDLE;
          err_n   = 1'b1;
        end
      end
      S_ACC: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (idx == LAST_IDX) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + addr_w'(1);
          state_n = S_FETCH;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (state_n == S_IDLE) abort_flag_n = 1'b0;
  end

  assign busy      = (state != S_IDLE);
  assign b_rd      = (state == S_FETCH);
  assign b_addr    = busy ? idx : '0;
  assign acc_idx   = busy ? idx : '0;
  assign il_en     = (state == S_ISSUE);
  assign acc_valid = (state == S_ACC);
  assign acc_last  = acc_valid && (idx == LAST_IDX);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_outer_loop_ctrl.sv
// tb_outer_loop_ctrl
//   Directed bench for outer_loop_ctrl. A B RAM model returns word k = k+1;
//   an inner-loop model answers il_en with en_out low in t+1 and high in t+5
//   (mode 0), holds the stale level through t+1 (mode 1), or never
//   completes (mode 2). Expected per-cycle outputs come from the documented
//   9-cycle digit schedule.
module tb_outer_loop_ctrl;

  localparam int RADIX = 78;
  localparam int DIGITS = 40;
  localparam int AW = 6;
  localparam int TO = 15;

  localparam int K_DONE = 0;
  localparam int K_ABORT = 1;
  localparam int K_ERR = 2;

  logic             clk, rst_n, start, abort;
  logic             busy, done, aborted, err, b_rd, il_en, il_en_out;
  logic             acc_valid, acc_last;
  logic [AW-1:0]    b_addr, acc_idx;
  logic [RADIX-1:0] b_rdata, il_bi;

  int n_cmp = 0;
  int n_bad = 0;
  int tick = 0;
  int t0 = 0;
  int il_mode = 0;

  outer_loop_ctrl #(.radix(RADIX), .digits(DIGITS), .addr_w(AW), .timeout(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .err(err),
    .b_rd(b_rd), .b_addr(b_addr), .b_rdata(b_rdata),
    .il_en(il_en), .il_bi(il_bi), .il_en_out(il_en_out),
    .acc_valid(acc_valid), .acc_idx(acc_idx), .acc_last(acc_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // B RAM: one-cycle read latency, word k holds k+1
  always @(posedge clk) if (b_rd) b_rdata <= RADIX'(b_addr) + RADIX'(1);

  // inner-loop model
  logic [2:0] il_cnt;
  logic       il_run;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      il_en_out <= 1'b0;
      il_cnt    <= '0;
      il_run    <= 1'b0;
    end else if (il_en) begin
      il_cnt <= 3'd4;
      il_run <= (il_mode != 2);
      if (il_mode != 1) il_en_out <= 1'b0;
    end else if (il_run) begin
      if (il_cnt == 3'd4 && il_mode == 1) il_en_out <= 1'b0;
      if (il_cnt == 3'd1) begin
        il_en_out <= 1'b1;
        il_run    <= 1'b0;
      end
      il_cnt <= il_cnt - 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {busy, b_rd, il_en, acc_valid, acc_last, done, aborted, err};
  endfunction

  function automatic logic [7:0] exp_flags(int c, int stop, int kind, bit to_mode);
    logic [7:0] f;
    int p;
    f = '0;
    p = c % 9;
    if (c < stop) begin
      f[7] = 1'b1;
      if (!(to_mode && c >= 5)) begin
        f[6] = (p == 1);
        f[5] = (p == 3);
        f[4] = (p == 0);
        f[3] = (c == 360);
      end
    end else if (c == stop) begin
      case (kind)
        K_DONE:  begin f[7] = 1'b1; f[2] = 1'b1; end
        K_ABORT: f[1] = 1'b1;
        default: f[0] = 1'b1;
      endcase
    end
    return f;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_flags"}, 128'(flags()), 128'(0));
    chk({tag, "_b_addr"}, 128'(b_addr), 128'(0));
    chk({tag, "_acc_idx"}, 128'(acc_idx), 128'(0));
  endtask

  // Start an operation in cycle 0, optionally pulse abort in cycle abort_cyc,
  // and check every cycle through stop+1 against the digit schedule.
  task automatic run_op(input string tag, input int abort_cyc, input int stop,
                        input int kind, input bit to_mode);
    int p, k, ea;
    bit bsy;
    @(negedge clk);
    start = 1'b1;
    t0 = tick;
    for (int c = 1; c <= stop + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("%s_cyc%0d", tag, c), 128'(tick - t0), 128'(c));
      p = c % 9;
      k = (c - 1) / 9;
      if (k > DIGITS - 1) k = DIGITS - 1;
      bsy = (c < stop) || (kind == K_DONE && c == stop);
      ea = (!bsy || to_mode) ? 0 : k;
      chk($sformatf("%s_flags@%0d", tag, c), 128'(flags()),
          128'(exp_flags(c, stop, kind, to_mode)));
      chk($sformatf("%s_b_addr@%0d", tag, c), 128'(b_addr), 128'(ea));
      chk($sformatf("%s_acc_idx@%0d", tag, c), 128'(acc_idx), 128'(ea));
      if (c < stop && (to_mode ? (c >= 3) : (p >= 3 || p == 0)))
        chk($sformatf("%s_il_bi@%0d", tag, c), 128'(il_bi), to_mode ? 128'(1) : 128'(k + 1));
      abort = (c == abort_cyc);
    end
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_il_bi", 128'(il_bi), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // start and abort together in IDLE: dropped, no pulse
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort_c1");
    @(negedge clk);
    chk_idle("start_abort_c2");

    il_mode = 0;
    run_op("nominal", -1, 361, K_DONE, 1'b0);
    il_mode = 1;
    run_op("stale", -1, 361, K_DONE, 1'b0);
    il_mode = 0;
    run_op("abort_load3", 29, 30, K_ABORT, 1'b0);
    run_op("abort_wait0", 6, 9, K_ABORT, 1'b0);
    run_op("abort_acc0", 9, 10, K_ABORT, 1'b0);
    il_mode = 2;
    run_op("timeout", -1, 20, K_ERR, 1'b1);
    il_mode = 0;
    run_op("restart", 15, 18, K_ABORT, 1'b0);

    // async reset between edges while in WAIT
    @(negedge clk);
    start = 1'b1;
    t0 = tick;
    @(negedge clk);
    start = 1'b0;
    while (tick - t0 < 6) @(negedge clk);
    chk("rst_mid_state_busy", 128'(busy), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_il_bi", 128'(il_bi), 128'(0));
    start = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("rst_hold_start");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    run_op("after_rst", 1, 2, K_ABORT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
